// File: rtl/controlador_hamming.sv
// Receive-side Hamming(7,4) controller: accepts a code word, computes its syndrome,
// corrects a single-bit error and hands the data nibble downstream with a saturating error count.
module controlador_hamming #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             entrada_valida,
   input  logic [6:0]       palabra_recibida,
   output logic             entrada_lista,
   output logic             salida_valida,
   input  logic             salida_lista,
   output logic [3:0]       datos_corregidos,
   output logic [2:0]       sindrome,
   output logic             error_detectado,
   input  logic             limpiar_contador,
   output logic [CNT_W-1:0] contador_errores
);

   typedef enum logic [1:0] {
      ESPERA     = 2'd0,
      CALCULO    = 2'd1,
      CORRECCION = 2'd2,
      ENTREGA    = 2'd3
   } estado_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   estado_t    estado_r;
   estado_t    estado_s;
   logic [6:0] palabra_r;
   logic [2:0] sindrome_r;
   logic [3:0] datos_s;

   // Syndrome value equals the 1-based position of the flipped bit
   function automatic logic [2:0] calcular_sindrome(input logic [6:0] w);
      return {w[3] ^ w[4] ^ w[5] ^ w[6],
              w[1] ^ w[2] ^ w[5] ^ w[6],
              w[0] ^ w[2] ^ w[4] ^ w[6]};
   endfunction

   // Only data positions (7,6,5,3) matter for the delivered nibble
   function automatic logic [3:0] extraer_datos(input logic [6:0] w, input logic [2:0] s);
      return {w[6] ^ (s == 3'd7),
              w[5] ^ (s == 3'd6),
              w[4] ^ (s == 3'd5),
              w[2] ^ (s == 3'd3)};
   endfunction

   assign datos_s       = extraer_datos(palabra_r, sindrome_r);
   assign entrada_lista = (estado_r == ESPERA) & ~rst;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_r <= ESPERA;
      end else begin
         estado_r <= estado_s;
      end
   end

   // Next-state logic
   always_comb begin
      estado_s = estado_r;
      case (estado_r)
         ESPERA: begin
            if (entrada_valida) begin
               estado_s = CALCULO;
            end else begin
               estado_s = ESPERA;
            end
         end
         CALCULO:    estado_s = CORRECCION;
         CORRECCION: estado_s = ENTREGA;
         ENTREGA: begin
            if (salida_lista) begin
               estado_s = ESPERA;
            end else begin
               estado_s = ENTREGA;
            end
         end
         default:    estado_s = ESPERA;
      endcase
   end

   // Captured word and its syndrome
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         palabra_r  <= 7'd0;
         sindrome_r <= 3'd0;
      end else begin
         if ((estado_r == ESPERA) && entrada_valida) begin
            palabra_r <= palabra_recibida;
         end else begin
            palabra_r <= palabra_r;
         end
         if (estado_r == CALCULO) begin
            sindrome_r <= calcular_sindrome(palabra_r);
         end else begin
            sindrome_r <= sindrome_r;
         end
      end
   end

   // Delivered outputs; data fields hold until the next correction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         salida_valida    <= 1'b0;
         datos_corregidos <= 4'd0;
         sindrome         <= 3'd0;
         error_detectado  <= 1'b0;
      end else begin
         case (estado_r)
            CORRECCION: begin
               salida_valida    <= 1'b1;
               datos_corregidos <= datos_s;
               sindrome         <= sindrome_r;
               error_detectado  <= (sindrome_r != 3'd0);
            end
            ENTREGA: begin
               if (salida_lista) begin
                  salida_valida <= 1'b0;
               end else begin
                  salida_valida <= 1'b1;
               end
            end
            default: begin
               salida_valida <= 1'b0;
            end
         endcase
      end
   end

   // Saturating error counter; clear wins over a simultaneous increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         contador_errores <= {CNT_W{1'b0}};
      end else if (limpiar_contador) begin
         contador_errores <= {CNT_W{1'b0}};
      end else if ((estado_r == CORRECCION) && (sindrome_r != 3'd0) &&
                   (contador_errores != CNT_MAX)) begin
         contador_errores <= contador_errores + CNT_W'(1);
      end else begin
         contador_errores <= contador_errores;
      end
   end

endmodule

// File: tb/tb_controlador_hamming.sv
// Self-checking bench for controlador_hamming: directed vector table, backpressure,
// saturation/clear and reset corner cases, then random words against a nearest-codeword model.
module tb_controlador_hamming;

   localparam int CNT_W = 2;
   localparam int CNT_SAT = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             entrada_valida = 1'b0;
   logic [6:0]       palabra_recibida = 7'd0;
   logic             entrada_lista;
   logic             salida_valida;
   logic             salida_lista = 1'b0;
   logic [3:0]       datos_corregidos;
   logic [2:0]       sindrome;
   logic             error_detectado;
   logic             limpiar_contador = 1'b0;
   logic [CNT_W-1:0] contador_errores;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   controlador_hamming #(.CNT_W(CNT_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .entrada_valida   (entrada_valida),
      .palabra_recibida (palabra_recibida),
      .entrada_lista    (entrada_lista),
      .salida_valida    (salida_valida),
      .salida_lista     (salida_lista),
      .datos_corregidos (datos_corregidos),
      .sindrome         (sindrome),
      .error_detectado  (error_detectado),
      .limpiar_contador (limpiar_contador),
      .contador_errores (contador_errores)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [6:0] w;
      logic [3:0] d;
      logic [2:0] s;
      logic       e;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: syndrome as XOR of 1-based positions of set bits,
   // data as the nibble of the nearest codeword (Hamming(7,4) is perfect).
   function automatic logic [6:0] encode(input logic [3:0] d);
      logic [6:0] w;
      w = 7'd0;
      w[6] = d[3]; w[5] = d[2]; w[4] = d[1]; w[2] = d[0];
      w[0] = w[2] ^ w[4] ^ w[6];
      w[1] = w[2] ^ w[5] ^ w[6];
      w[3] = w[4] ^ w[5] ^ w[6];
      return w;
   endfunction

   function automatic logic [2:0] model_syn(input logic [6:0] w);
      logic [2:0] s;
      s = 3'd0;
      for (int i = 0; i < 7; i++) begin
         if (w[i]) s = s ^ 3'(i + 1);
      end
      return s;
   endfunction

   function automatic logic [3:0] model_data(input logic [6:0] w);
      logic [3:0] r;
      r = 4'd0;
      for (int d = 0; d < 16; d++) begin
         if ($countones(encode(4'(d)) ^ w) <= 1) r = 4'(d);
      end
      return r;
   endfunction

   task automatic process_word(input logic [6:0] w, input logic [3:0] ed, input logic [2:0] es,
                               input logic ee, input int hold, input bit inject, input bit clr);
      @(negedge clk);
      chk("entrada_lista_espera", entrada_lista, 1);
      entrada_valida = 1'b1;
      palabra_recibida = w;
      salida_lista = (hold == 0);
      @(negedge clk);
      entrada_valida = 1'b0;
      chk("salida_valida_calculo", salida_valida, 0);
      chk("entrada_lista_calculo", entrada_lista, 0);
      @(negedge clk);
      chk("salida_valida_correccion", salida_valida, 0);
      if (clr) begin
         limpiar_contador = 1'b1;
         exp_cnt = 0;
      end else if (ee && exp_cnt < CNT_SAT) begin
         exp_cnt++;
      end
      @(negedge clk);
      limpiar_contador = 1'b0;
      chk("salida_valida_entrega", salida_valida, 1);
      chk("datos_corregidos", datos_corregidos, ed);
      chk("sindrome", sindrome, es);
      chk("error_detectado", error_detectado, ee);
      chk("contador_errores", contador_errores, exp_cnt);
      for (int i = 0; i < hold; i++) begin
         if (inject) begin
            entrada_valida = 1'b1;
            palabra_recibida = ~w;
         end
         @(negedge clk);
         chk("hold_salida_valida", salida_valida, 1);
         chk("hold_datos", datos_corregidos, ed);
         chk("hold_sindrome", sindrome, es);
         chk("hold_entrada_lista", entrada_lista, 0);
      end
      salida_lista = 1'b1;
      entrada_valida = 1'b0;
      @(negedge clk);
      chk("post_salida_valida", salida_valida, 0);
      chk("post_entrada_lista", entrada_lista, 1);
      chk("post_datos_held", datos_corregidos, ed);
      if (inject) begin
         @(negedge clk);
         chk("no_second_word", salida_valida, 0);
         chk("still_espera", entrada_lista, 1);
      end
   endtask

   initial begin
      vec_t tbl[7];
      logic [6:0] w;
      logic [2:0] s;

      tbl[0] = '{7'h55, 4'b1011, 3'b000, 1'b0};
      tbl[1] = '{7'h45, 4'b1011, 3'b101, 1'b1};
      tbl[2] = '{7'h54, 4'b1011, 3'b001, 1'b1};
      tbl[3] = '{7'h7F, 4'b1111, 3'b000, 1'b0};
      tbl[4] = '{7'h40, 4'b0000, 3'b111, 1'b1};
      tbl[5] = '{7'h5D, 4'b1011, 3'b100, 1'b1};
      tbl[6] = '{7'h03, 4'b0001, 3'b011, 1'b1};

      // Reset values while rst is held
      repeat (2) @(negedge clk);
      chk("rst_entrada_lista", entrada_lista, 0);
      chk("rst_salida_valida", salida_valida, 0);
      chk("rst_datos", datos_corregidos, 0);
      chk("rst_sindrome", sindrome, 0);
      chk("rst_error", error_detectado, 0);
      chk("rst_contador", contador_errores, 0);
      rst = 1'b0;
      #1;
      chk("release_entrada_lista", entrada_lista, 1);

      // Directed vector table
      for (int i = 0; i < 7; i++) begin
         process_word(tbl[i].w, tbl[i].d, tbl[i].s, tbl[i].e, 0, 1'b0, 1'b0);
      end

      // Backpressure with an ignored second word
      process_word(7'h45, 4'b1011, 3'b101, 1'b1, 5, 1'b1, 1'b0);

      // Saturation: clear, then five error words
      @(negedge clk);
      limpiar_contador = 1'b1;
      @(negedge clk);
      limpiar_contador = 1'b0;
      exp_cnt = 0;
      chk("clear_idle", contador_errores, 0);
      for (int i = 0; i < 5; i++) begin
         process_word(7'h45, 4'b1011, 3'b101, 1'b1, 0, 1'b0, 1'b0);
      end
      // Clear at the increment edge, saturated and non-saturated
      process_word(7'h54, 4'b1011, 3'b001, 1'b1, 0, 1'b0, 1'b1);
      process_word(7'h54, 4'b1011, 3'b001, 1'b1, 0, 1'b0, 1'b0);
      process_word(7'h45, 4'b1011, 3'b101, 1'b1, 0, 1'b0, 1'b1);
      process_word(7'h40, 4'b0000, 3'b111, 1'b1, 0, 1'b0, 1'b0);
      process_word(7'h45, 4'b1011, 3'b101, 1'b1, 0, 1'b0, 1'b0);

      // Reset during CORRECCION
      @(negedge clk);
      entrada_valida = 1'b1;
      palabra_recibida = 7'h45;
      @(negedge clk);
      entrada_valida = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_entrada_lista", entrada_lista, 0);
      chk("midrst_salida_valida", salida_valida, 0);
      chk("midrst_datos", datos_corregidos, 0);
      chk("midrst_sindrome", sindrome, 0);
      chk("midrst_error", error_detectado, 0);
      chk("midrst_contador", contador_errores, 0);
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = 0;
      @(negedge clk);
      chk("midrst_no_delivery", salida_valida, 0);
      process_word(7'h55, 4'b1011, 3'b000, 1'b0, 0, 1'b0, 1'b0);

      // Random words against the reference model
      for (int i = 0; i < 40; i++) begin
         w = 7'($urandom_range(0, 127));
         s = model_syn(w);
         process_word(w, model_data(w), s, (s != 3'd0), $urandom_range(0, 3), 1'b0,
                      ($urandom_range(0, 4) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/controlador_hamming.md
# controlador_hamming

Receive-side controller for the Hamming(7,4) path. It accepts 7-bit code words over a valid/ready handshake and sequences each word through syndrome calculation, single-bit correction and delivery. It then returns the corrected 4-bit data word and keeps a saturating count of corrected errors. It sits between the serial/parallel receive front end and the consumer of data nibbles (display/LED logic).

## Interface
- CNT_W, 8, width of the corrected-error counter
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- entrada_valida  input  1  upstream word valid
- palabra_recibida  input  7  received word, bit order [i3,i2,i1,c2,i0,c1,c0] (bit 6..0)
- entrada_lista  output  1  controller ready to accept a word
- salida_valida  output  1  corrected data available
- salida_lista  input  1  downstream ready
- datos_corregidos  output  4  corrected data [i3,i2,i1,i0]
- sindrome  output  3  syndrome [p2,p1,p0] of the delivered word
- error_detectado  output  1  delivered word had nonzero syndrome
- limpiar_contador  input  1  synchronous clear of the counter
- contador_errores  output  CNT_W  number of words with nonzero syndrome, saturating

## Operation
- FSM states: ESPERA, CALCULO, CORRECCION, ENTREGA. Reset state is ESPERA.
- ESPERA: entrada_lista=1. When entrada_valida=1, register palabra_recibida and go to CALCULO. Otherwise stay.
- CALCULO: register the syndrome from the stored word. Go to CORRECCION.
  - p0 = b0^b2^b4^b6
  - p1 = b1^b2^b5^b6
  - p2 = b3^b4^b5^b6
- CORRECCION: if syndrome s≠0, invert stored bit index s−1 (syndrome value = 1-based position). If s=0, do nothing. Register datos_corregidos = {b6,b5,b4,b2} of the corrected word, register sindrome, and set error_detectado=(s≠0). Go to ENTREGA.
- ENTREGA: salida_valida=1. Outputs are held stable until salida_lista=1, then return to ESPERA.
- Counter increments by 1 on the CORRECCION→ENTREGA transition when s≠0. It saturates at 2^CNT_W−1 and never wraps.
- limpiar_contador=1 sets the counter to 0 next edge. It has priority over a simultaneous increment.
- Double-bit errors are not detected. They are miscorrected as single errors; this is accepted behaviour for (7,4) SEC.
- entrada_valida while not in ESPERA is ignored. The upstream must hold its word until entrada_lista.

## Timing
- Reset values:
  - state ESPERA
  - entrada_lista=0 while rst=1, 1 after release
  - salida_valida=0
  - datos_corregidos=0
  - sindrome=0
  - error_detectado=0
  - contador_errores=0
- entrada_lista = (state==ESPERA) and not rst. It is combinational from state.
- Handshake at edge N (entrada_valida & entrada_lista): CALCULO in N+1, CORRECCION in N+2, salida_valida=1 from N+3.
- Minimum latency is 3 cycles accept-to-valid. Maximum throughput is one word per 4 cycles with salida_lista tied high.
- Delivery completes at the edge where salida_valida & salida_lista. salida_valida is 0 and entrada_lista is 1 in the following cycle.
- datos_corregidos, sindrome and error_detectado hold their last values after delivery until the next CORRECCION.
- Counter value updates on the same edge salida_valida rises.
- rst asserted in any state, including ENTREGA with backpressure: immediate return to reset values, and the in-flight word is discarded.

## Test plan
- Clean word: 7'h55 (data 4'b1011), salida_lista=1 → after 3 cycles datos_corregidos=4'b1011, sindrome=3'b000, error_detectado=0, counter stays 0.
- Data-bit error: 7'h45 (i1 flipped) → sindrome=3'b101, datos_corregidos=4'b1011, error_detectado=1, contador_errores=1.
- Check-bit error: 7'h54 (c0 flipped) → sindrome=3'b001, datos_corregidos=4'b1011, counter increments.
- Backpressure: 7'h45 with salida_lista=0 for 5 cycles → salida_valida, datos_corregidos and sindrome stable, entrada_lista=0 and a second entrada_valida ignored. Release → delivered once, entrada_lista=1 next cycle.
- Saturation/clear: CNT_W=2, five error words → counter 1,2,3,3,3. Then limpiar_contador together with a sixth error word's increment edge → counter 0.
- Reset mid-operation: assert rst in CORRECCION → all outputs at reset values asynchronously. After release, the next word 7'h55 is processed normally with 3-cycle latency.
